// File: rtl/cvxif_sched_pkg.sv
// Shared types for the CV-X-IF execution scheduler: FSM states, buffer entry layout
// and the fixed operand/identifier widths the scheduler is built around.
package cvxif_sched_pkg;

  localparam int unsigned SchedXlen        = 32;
  localparam int unsigned SchedNrRgprPorts = 2;

  typedef logic [3:0] opcode_t;   // 0 is the ILLEGAL opcode
  typedef logic [1:0] hartid_t;
  typedef logic [3:0] id_t;

  localparam opcode_t OPC_ILLEGAL = 4'd0;
  localparam opcode_t OPC_ADD     = 4'd1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } sched_state_e;

  typedef struct packed {
    opcode_t                                    opcode;
    hartid_t                                    hartid;
    id_t                                        id;
    logic [4:0]                                 rd;
    logic                                       we;
    logic [SchedNrRgprPorts*SchedXlen-1:0]      rs;
    logic                                       committed;
    logic                                       killed;
  } sched_entry_t;

endpackage

// File: rtl/cvxif_sched_buffer.sv
// In-order circular instruction buffer. Holds decoded instructions until the
// scheduler pops them, and applies commit/kill transactions to the oldest
// matching live entry (or to the entry being written this cycle).
module cvxif_sched_buffer
  import cvxif_sched_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  sched_entry_t                 push_entry_i,
  input  logic                         pop_i,
  input  logic                         commit_valid_i,
  input  hartid_t                      commit_hartid_i,
  input  id_t                          commit_id_i,
  input  logic                         commit_kill_i,
  output logic                         full_o,
  output logic                         head_valid_o,
  output sched_entry_t                 head_entry_o,
  output logic [$clog2(Depth+1)-1:0]   occupancy_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);
  typedef logic [PtrW-1:0] ptr_t;

  sched_entry_t      entries_reg [Depth];
  logic [Depth-1:0]  valid_reg;
  ptr_t              head_reg;
  ptr_t              tail_reg;
  logic [CntW-1:0]   count_reg;

  ptr_t              age_idx   [Depth];
  logic [Depth-1:0]  age_match;
  logic              mark_hit;
  ptr_t              mark_idx;
  logic              push_match;
  sched_entry_t      push_entry_next;

  // Age-ordered view: slot gi is the gi-th oldest entry. A commit only takes a
  // fresh entry; a kill may also take a committed one so an in-flight
  // instruction can still be squashed while it executes.
  for (genvar gi = 0; gi < Depth; gi++) begin : g_age
    assign age_idx[gi]   = head_reg + ptr_t'(gi);
    assign age_match[gi] = commit_valid_i
                         && valid_reg[age_idx[gi]]
                         && (entries_reg[age_idx[gi]].hartid == commit_hartid_i)
                         && (entries_reg[age_idx[gi]].id == commit_id_i)
                         && !entries_reg[age_idx[gi]].killed
                         && (commit_kill_i || !entries_reg[age_idx[gi]].committed);
  end

  // Pick the oldest matching entry; fall back to the entry being pushed.
  always_comb begin
    mark_hit = 1'b0;
    mark_idx = '0;
    for (int k = int'(Depth) - 1; k >= 0; k--) begin
      if (age_match[k]) begin
        mark_hit = 1'b1;
        mark_idx = age_idx[k];
      end
    end
    push_match = commit_valid_i && !mark_hit
               && (push_entry_i.hartid == commit_hartid_i)
               && (push_entry_i.id == commit_id_i);
    push_entry_next           = push_entry_i;
    push_entry_next.committed = push_match && !commit_kill_i;
    push_entry_next.killed    = push_match && commit_kill_i;
  end

  // Entry storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(Depth); k++) entries_reg[k] <= '0;
      valid_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (mark_hit) begin
        if (commit_kill_i) entries_reg[mark_idx].killed    <= 1'b1;
        else               entries_reg[mark_idx].committed <= 1'b1;
      end
      if (push_i) begin
        entries_reg[tail_reg] <= push_entry_next;
        valid_reg[tail_reg]   <= 1'b1;
        tail_reg              <= tail_reg + ptr_t'(1);
      end
      if (pop_i) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + ptr_t'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_reg <= count_reg + CntW'(1);
        2'b01:   count_reg <= count_reg - CntW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign full_o       = (count_reg == CntW'(Depth));
  assign head_valid_o = valid_reg[head_reg];
  assign head_entry_o = entries_reg[head_reg];
  assign occupancy_o  = count_reg;

endmodule

// File: rtl/cvxif_exec_scheduler.sv
// Sequences committed CV-X-IF instructions one at a time through the shared
// execution unit and returns their results in issue order.
module cvxif_exec_scheduler
  import cvxif_sched_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  opcode_t                               in_opcode_i,
  input  hartid_t                               in_hartid_i,
  input  id_t                                   in_id_i,
  input  logic [4:0]                            in_rd_i,
  input  logic                                  in_we_i,
  input  logic [SchedNrRgprPorts*SchedXlen-1:0] in_rs_i,
  input  logic                                  commit_valid_i,
  input  hartid_t                               commit_hartid_i,
  input  id_t                                   commit_id_i,
  input  logic                                  commit_kill_i,
  output logic                                  exe_valid_o,
  input  logic                                  exe_ready_i,
  output opcode_t                               exe_opcode_o,
  output logic [SchedNrRgprPorts*SchedXlen-1:0] exe_rs_o,
  input  logic                                  exe_done_i,
  input  logic [SchedXlen-1:0]                  exe_data_i,
  output logic                                  result_valid_o,
  input  logic                                  result_ready_i,
  output hartid_t                               result_hartid_o,
  output id_t                                   result_id_o,
  output logic [4:0]                            result_rd_o,
  output logic                                  result_we_o,
  output logic [SchedXlen-1:0]                  result_data_o,
  output logic [$clog2(Depth+1)-1:0]            occupancy_o
);

  sched_state_e         state_reg, state_next;
  logic                 full;
  logic                 head_valid;
  sched_entry_t         head_entry;
  sched_entry_t         push_entry;
  logic                 push;
  logic                 pop;
  logic                 capture;
  hartid_t              res_hartid_reg;
  id_t                  res_id_reg;
  logic [4:0]           res_rd_reg;
  logic                 res_we_reg;
  logic [SchedXlen-1:0] res_data_reg;

  assign in_ready_o = !full;
  assign push       = in_valid_i && in_ready_o;

  // Assemble the buffer entry; commit flags are resolved inside the buffer.
  always_comb begin
    push_entry        = '0;
    push_entry.opcode = in_opcode_i;
    push_entry.hartid = in_hartid_i;
    push_entry.id     = in_id_i;
    push_entry.rd     = in_rd_i;
    push_entry.we     = in_we_i;
    push_entry.rs     = in_rs_i;
  end

  cvxif_sched_buffer #(
    .Depth (Depth)
  ) u_buffer (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .push_i          (push),
    .push_entry_i    (push_entry),
    .pop_i           (pop),
    .commit_valid_i  (commit_valid_i),
    .commit_hartid_i (commit_hartid_i),
    .commit_id_i     (commit_id_i),
    .commit_kill_i   (commit_kill_i),
    .full_o          (full),
    .head_valid_o    (head_valid),
    .head_entry_o    (head_entry),
    .occupancy_o     (occupancy_o)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state, dispatch request, pop and result capture decisions.
  always_comb begin
    state_next  = state_reg;
    exe_valid_o = 1'b0;
    pop         = 1'b0;
    capture     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (head_valid) begin
          if (head_entry.killed) begin
            pop = 1'b1;
          end else if (head_entry.committed) begin
            exe_valid_o = 1'b1;
            if (exe_ready_i) state_next = EXEC;
          end
        end
      end
      EXEC: begin
        if (exe_done_i) begin
          if (head_entry.killed) begin
            pop        = 1'b1;
            state_next = IDLE;
          end else begin
            capture    = 1'b1;
            state_next = RESP;
          end
        end
      end
      RESP: begin
        if (result_ready_i) begin
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result register: frozen from execution done until the core takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_hartid_reg <= '0;
      res_id_reg     <= '0;
      res_rd_reg     <= '0;
      res_we_reg     <= 1'b0;
      res_data_reg   <= '0;
    end else if (capture) begin
      res_hartid_reg <= head_entry.hartid;
      res_id_reg     <= head_entry.id;
      res_rd_reg     <= head_entry.rd;
      res_we_reg     <= head_entry.we;
      res_data_reg   <= exe_data_i;
    end
  end

  assign exe_opcode_o    = exe_valid_o ? head_entry.opcode : OPC_ILLEGAL;
  assign exe_rs_o        = exe_valid_o ? head_entry.rs : '0;
  assign result_valid_o  = (state_reg == RESP);
  assign result_hartid_o = res_hartid_reg;
  assign result_id_o     = res_id_reg;
  assign result_rd_o     = res_rd_reg;
  assign result_we_o     = res_we_reg;
  assign result_data_o   = res_data_reg;

endmodule
